// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM state type, width derivations and build-time defaults for fir_ctrl
//   DEF_DATA_WIDTH / DEF_NUM_REGS come from `DATA_WIDTH / `NUM_REGS (16 / 8 when not supplied)
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef NUM_REGS
`define NUM_REGS 8
`endif
package fir_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, MAC, OUT} state_t;
   localparam int DEF_DATA_WIDTH = `DATA_WIDTH;
   localparam int DEF_NUM_REGS = `NUM_REGS;
   function automatic int acc_width(input int dw, input int cw, input int n);
      return dw + cw + $clog2(n);
   endfunction
   function automatic int frac_bits(input int cw);
      return cw - 1;
   endfunction
endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: NUM_REGS x COEF_WIDTH coefficient register file
//   clk, rst         : clock, synchronous active-high reset (clears every entry)
//   we, waddr, wdata : synchronous write, addresses >= NUM_REGS are dropped
//   raddr, rdata     : asynchronous read
module fir_coef_bank #(
   parameter int NUM_REGS = 8,
   parameter int COEF_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        we,
   input  logic [$clog2(NUM_REGS)-1:0] waddr,
   input  logic [COEF_WIDTH-1:0]       wdata,
   input  logic [$clog2(NUM_REGS)-1:0] raddr,
   output logic [COEF_WIDTH-1:0]       rdata
);
   logic [COEF_WIDTH-1:0] mem [NUM_REGS];
   always_ff @(posedge clk)
      if (rst)
         for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      else if (we && 32'(waddr) < NUM_REGS)
         mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/fir_ctrl.sv
// fir_ctrl: sequential FIR controller, one multiply-accumulate per cycle over an external shift register
//   clk, rst                      : clock, synchronous active-high reset
//   s_valid, s_ready, s_data      : input sample handshake
//   sr_shift_en, sr_data_in       : shift-register advance strobe and sample presented to it
//   sr_taps                       : shift-register taps, tap 0 (newest) in the low DATA_WIDTH bits
//   coef_we, coef_addr, coef_wdata: coefficient write port, honoured only while idle
//   m_valid, m_ready, m_data      : filtered result handshake
//   m_sat                         : result was clipped
//   busy                          : controller not idle
//   FIR_CTRL_SAT_EN               : when defined, results saturate; otherwise they wrap and m_sat stays 0
module fir_ctrl
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int COEF_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [DATA_WIDTH-1:0]         s_data,
   output logic                          sr_shift_en,
   output logic [DATA_WIDTH-1:0]         sr_data_in,
   input  logic [DATA_WIDTH*NUM_REGS-1:0] sr_taps,
   input  logic                          coef_we,
   input  logic [$clog2(NUM_REGS)-1:0]   coef_addr,
   input  logic [COEF_WIDTH-1:0]         coef_wdata,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [DATA_WIDTH-1:0]         m_data,
   output logic                          m_sat,
   output logic                          busy
);
   localparam int AW = $clog2(NUM_REGS);
   localparam int ACC_W = acc_width(DATA_WIDTH, COEF_WIDTH, NUM_REGS);
   localparam int FRAC = frac_bits(COEF_WIDTH);
   state_t state;
   logic [AW-1:0] tap_idx;
   logic [DATA_WIDTH-1:0] sample;
   logic signed [ACC_W-1:0] acc;
   logic signed [DATA_WIDTH+COEF_WIDTH-1:0] prod;
   logic [COEF_WIDTH-1:0] coef;
   logic [DATA_WIDTH-1:0] narrow;
   logic sat;
   fir_coef_bank #(.NUM_REGS(NUM_REGS), .COEF_WIDTH(COEF_WIDTH)) u_coef (
      .clk(clk),
      .rst(rst),
      .we(coef_we && state == IDLE),
      .waddr(coef_addr),
      .wdata(coef_wdata),
      .raddr(tap_idx),
      .rdata(coef)
   );
   assign prod = $signed(sr_taps[tap_idx*DATA_WIDTH +: DATA_WIDTH]) * $signed(coef);
   assign s_ready = state == IDLE;
   assign busy = state != IDLE;
   assign sr_shift_en = state == SHIFT;
   assign sr_data_in = sample;
`ifdef FIR_CTRL_SAT_EN
   // the shifted result fits only if every bit above its sign bit matches the sign bit
   assign sat = !(&acc[ACC_W-1:FRAC+DATA_WIDTH-1] || !(|acc[ACC_W-1:FRAC+DATA_WIDTH-1]));
   assign narrow = sat ? {acc[ACC_W-1], {(DATA_WIDTH-1){~acc[ACC_W-1]}}} : acc[FRAC+DATA_WIDTH-1:FRAC];
`else
   assign sat = 1'b0;
   assign narrow = acc[FRAC+DATA_WIDTH-1:FRAC];
`endif
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         acc <= '0;
         tap_idx <= '0;
         sample <= '0;
         m_valid <= 1'b0;
         m_data <= '0;
         m_sat <= 1'b0;
      end else
         case (state)
            IDLE:
               if (s_valid) begin
                  sample <= s_data;
                  state <= SHIFT;
               end
            SHIFT: begin
               acc <= '0;
               tap_idx <= '0;
               state <= MAC;
            end
            MAC: begin
               acc <= acc + ACC_W'(prod);
               tap_idx <= tap_idx + 1'b1;
               if (32'(tap_idx) == NUM_REGS - 1) state <= OUT;
            end
            default:
               // first OUT cycle registers the narrowed result, then it is held until taken
               if (!m_valid) begin
                  m_valid <= 1'b1;
                  m_data <= narrow;
                  m_sat <= sat;
               end else if (m_ready) begin
                  m_valid <= 1'b0;
                  state <= IDLE;
               end
         endcase
endmodule

// File: doc/fir_ctrl.md
FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default `DATA_WIDTH, sample/output width; NUM_REGS, default `NUM_REGS, tap count (>=2); COEF_WIDTH, default 16, signed Q1.(COEF_WIDTH-1) coefficient width.
REQ-002 Ports SHALL be (name direction width meaning):
  clk  in  1  single clock, rising edge
  rst  in  1  reset, synchronous, active-high
  s_valid  in  1  input sample offered
  s_ready  out  1  controller accepts sample
  s_data  in  DATA_WIDTH  signed input sample
  sr_shift_en  out  1  shift-register advance strobe
  sr_data_in  out  DATA_WIDTH  sample presented to shift register
  sr_taps  in  DATA_WIDTH x NUM_REGS  shift-register parallel taps, [0] newest
  coef_we  in  1  coefficient write strobe
  coef_addr  in  $clog2(NUM_REGS)  coefficient index
  coef_wdata  in  COEF_WIDTH  signed coefficient
  m_valid  out  1  filtered result valid
  m_ready  in  1  downstream accepts result
  m_data  out  DATA_WIDTH  signed filtered result
  m_sat  out  1  result was clipped
  busy  out  1  state != IDLE

Function
REQ-003 FSM states SHALL be IDLE, SHIFT, MAC, OUT.
REQ-004 IDLE: s_ready=1; on s_valid capture s_data into sample register, go to SHIFT.
REQ-005 SHIFT: one cycle; sr_shift_en=1, sr_data_in=captured sample; clear acc and tap_idx; go to MAC.
REQ-006 MAC: one tap per cycle, acc += sr_taps[tap_idx]*coef[tap_idx], both signed; after tap_idx==NUM_REGS-1 go to OUT; NUM_REGS cycles total.
REQ-007 OUT: m_valid=1, m_data/m_sat held stable until m_valid&&m_ready, then IDLE; no sample accepted in same cycle.
REQ-008 Latency: accept at edge T -> m_valid high from edge T+NUM_REGS+2.
REQ-009 s_ready SHALL be 0 in SHIFT, MAC, OUT; sr_shift_en SHALL be 0 outside SHIFT; sr_data_in SHALL hold captured sample.
REQ-010 Accumulator width SHALL be DATA_WIDTH+COEF_WIDTH+$clog2(NUM_REGS), no internal overflow.
REQ-011 Result SHALL be acc arithmetic-shifted right by COEF_WIDTH-1 (truncation toward minus infinity), then narrowed per REQ-017/018.
REQ-012 Coefficient writes SHALL be accepted only in IDLE; coef_we in other states ignored.
REQ-013 coef_we and s_valid in same IDLE cycle: both performed; new coefficient used for that sample.
REQ-014 coef_addr >= NUM_REGS SHALL be ignored.

Reset
REQ-015 rst SHALL force IDLE, acc=0, tap_idx=0, sample=0, all coefficients=0, m_valid=0, m_data=0, m_sat=0, sr_shift_en=0, busy=0, s_ready=1 next cycle; applies mid-operation, in-flight result discarded.

Configuration
REQ-016 Macro FIR_CTRL_SAT_EN SHALL select output narrowing.
REQ-017 Defined: result clipped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; m_sat=1 when clipped.
REQ-018 Undefined: low DATA_WIDTH bits kept (wrap); m_sat tied 0; port still present.

Structure
REQ-019 Package fir_pkg SHALL hold FSM state enum, ACC_WIDTH/FRAC_BITS derivation functions, defaults from `DATA_WIDTH/`NUM_REGS.
REQ-020 Sub-module fir_coef_bank (NUM_REGS x COEF_WIDTH register file, sync write, async read) SHALL be instantiated once.

Verification (DATA_WIDTH=16, COEF_WIDTH=16, NUM_REGS=8, shiftReg instantiated, shift gated by sr_shift_en)
REQ-021 Reset pulse -> m_valid=0, m_data=0, busy=0, s_ready=1; readback result of next sample with no coef writes = 0.
REQ-022 All coefs 0x4000, eight samples of 100 -> m_data 50,100,...,400.
REQ-023 Sample accepted edge T -> sr_shift_en high exactly cycle T+1, m_valid high edge T+10; m_ready=0 for 5 cycles -> m_data stable, s_ready=0.
REQ-024 Coefs 0x7FFF, eight samples 32767 -> with FIR_CTRL_SAT_EN m_data=32767, m_sat=1; without m_data=0xFFF0 (-16), m_sat=0.
REQ-025 rst asserted during MAC cycle 4 -> next cycle IDLE, m_valid=0, all coefs read 0.
REQ-026 coef_we (addr 0, 0x7FFF) during MAC -> ignored, current and next result unchanged.
